// File: rtl/wbs_rgb_pwm_pkg.sv
// Shared constants and types for the Wishbone RGB PWM block.
// fade_step is only referenced when WBS_RGB_PWM_FADE_EN is defined.
package wbs_rgb_pwm_pkg;

  localparam logic [1:0] ADR_R    = 2'd0;
  localparam logic [1:0] ADR_G    = 2'd1;
  localparam logic [1:0] ADR_B    = 2'd2;
  localparam logic [1:0] ADR_CTRL = 2'd3;

  localparam int unsigned CTRL_EN_BIT = 0;

  typedef logic [7:0] duty_t;

  // One step of the shadow toward its target; holds when already equal.
  function automatic duty_t fade_step(input duty_t cur, input duty_t tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

endpackage

// File: rtl/wbs_rgb_pwm_channel.sv
// One PWM colour channel: shadow duty register, optional fade stepper
// (WBS_RGB_PWM_FADE_EN) and the registered compare against pwm_cnt.
module pwm_channel
  import wbs_rgb_pwm_pkg::*;
`ifdef WBS_RGB_PWM_FADE_EN
  #(parameter int unsigned FADE_DIV = 255)
`endif
  (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       wrap,
  input  logic       enable,
  input  logic [7:0] pwm_cnt,
  input  duty_t      duty,
  output logic       led
);

  duty_t shadow;
  logic  step;

  assign step = tick & wrap;

`ifdef WBS_RGB_PWM_FADE_EN
  localparam int unsigned FW = (FADE_DIV > 0) ? $clog2(FADE_DIV + 1) : 1;

  logic [FW-1:0] fade_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      fade_cnt <= '0;
    end else if (step) begin
      if (fade_cnt == FW'(FADE_DIV)) begin
        fade_cnt <= '0;
        shadow   <= fade_step(shadow, duty);
      end else begin
        fade_cnt <= fade_cnt + FW'(1);
      end
    end
  end
`else
  // Loading only at the wrap keeps a mid-period write out of the current period.
  always_ff @(posedge clk) begin
    if (rst)       shadow <= '0;
    else if (step) shadow <= duty;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) led <= 1'b0;
    else     led <= enable & (pwm_cnt < shadow);
  end

endmodule

// File: rtl/wbs_rgb_pwm.sv
// Wishbone classic responder driving three PWM LED levels from a shared
// prescaled 8-bit counter. Optional fade: define WBS_RGB_PWM_FADE_EN.
module wbs_rgb_pwm
  import wbs_rgb_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 47
`ifdef WBS_RGB_PWM_FADE_EN
  , parameter int unsigned FADE_DIV = 255
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);

  localparam int unsigned PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic          tick;
  logic          wrap;

  duty_t duty_r, duty_g, duty_b;
  logic  enable;
  logic  req;
  duty_t rd_data;

  duty_t duty_v [3];
  logic [2:0] led_v;

  assign tick = (presc == PW'(PRESCALE));
  assign wrap = tick & (pwm_cnt == 8'hFF);
  // Gating on !ack turns a held strobe into one ack every other cycle.
  assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + PW'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_R:    rd_data = duty_r;
      ADR_G:    rd_data = duty_g;
      ADR_B:    rd_data = duty_b;
      ADR_CTRL: rd_data = {7'd0, enable};
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      duty_r   <= '0;
      duty_g   <= '0;
      duty_b   <= '0;
      enable   <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rd_data : '0;
      if (req & wb_we_i) begin
        case (wb_adr_i)
          ADR_R:    duty_r <= wb_dat_i;
          ADR_G:    duty_g <= wb_dat_i;
          ADR_B:    duty_b <= wb_dat_i;
          ADR_CTRL: enable <= wb_dat_i[CTRL_EN_BIT];
          default:  ;
        endcase
      end
    end
  end

  assign duty_v[0] = duty_r;
  assign duty_v[1] = duty_g;
  assign duty_v[2] = duty_b;

  for (genvar i = 0; i < 3; i++) begin : g_ch
`ifdef WBS_RGB_PWM_FADE_EN
    pwm_channel #(.FADE_DIV(FADE_DIV)) u_ch (
`else
    pwm_channel u_ch (
`endif
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .wrap    (wrap),
      .enable  (enable),
      .pwm_cnt (pwm_cnt),
      .duty    (duty_v[i]),
      .led     (led_v[i])
    );
  end

  assign led_r = led_v[0];
  assign led_g = led_v[1];
  assign led_b = led_v[2];

endmodule
